// File: rtl/tdc_tap_capture.sv
// ---------------------------------------------------------------------------
// tdc_tap_capture
//   Front end of a delay-line TDC. It double-registers the raw tap flops and
//   detects a hit on the first cycle the synchronised word leaves zero. It
//   then captures that thermometer word together with a free-running coarse
//   timestamp and holds both for a downstream decoder with a valid/ready
//   handshake. After a hit is accepted, a dead-time window follows. Hits
//   seen while a word is pending or during the dead window are dropped and
//   reported on oMissed.
//
// Ports
//   iClk     in   clock, rising edge
//   iRstn    in   asynchronous active-low reset
//   iTaps    in   [NUM]       raw tap flop outputs, bit 0 nearest line entry
//   iArm     in   level, enables hit capture
//   iReady   in   decoder accepts the current word
//   oFF      out  [NUM]       captured thermometer word (unmodified)
//   oCoarse  out  [COARSE_W]  coarse count in the hit-detect cycle
//   oValid   out  oFF/oCoarse hold a hit not yet accepted
//   oBusy    out  high in HOLD and DEAD
//   oMissed  out  one-cycle pulse when a hit is dropped
// ---------------------------------------------------------------------------
module tdc_tap_capture #(
    parameter int NUM      = 12,
    parameter int COARSE_W = 16,
    parameter int DEAD     = 4
) (
    input  logic                iClk,
    input  logic                iRstn,
    input  logic [NUM-1:0]      iTaps,
    input  logic                iArm,
    input  logic                iReady,
    output logic [NUM-1:0]      oFF,
    output logic [COARSE_W-1:0] oCoarse,
    output logic                oValid,
    output logic                oBusy,
    output logic                oMissed
);

    // The dead counter must hold DEAD-1. It keeps at least one bit so that
    // DEAD of 0 or 1 still elaborates.
    localparam int DW = (DEAD > 1) ? $clog2(DEAD) : 1;
    localparam logic [DW-1:0] DEAD_LD = (DEAD > 0) ? DW'(DEAD - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_HOLD  = 2'd2,
        S_DEAD  = 2'd3
    } state_t;

    state_t                state_q;
    logic [NUM-1:0]        s1_q, s2_q;
    logic [COARSE_W-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]         dcnt_q;
    logic [NUM-1:0]        ff_q;
    logic [COARSE_W-1:0]   coarse_q;
    logic                  valid_q, busy_q, missed_q;
    logic                  hit;
    logic                  blocked;

    // Rising edge of "any tap set" on the synchronised word.
    assign hit     = (|s1_q) && !(|s2_q);
    // A hit is dropped while a word is pending or the line is still settling.
    assign blocked = (state_q == S_HOLD) || (state_q == S_DEAD);
    // Free-running counter. It wraps silently.
    assign cnt_d   = cnt_q + 1'b1;

    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            state_q  <= S_IDLE;
            s1_q     <= '0;
            s2_q     <= '0;
            cnt_q    <= '0;
            dcnt_q   <= '0;
            ff_q     <= '0;
            coarse_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            missed_q <= 1'b0;
        end else begin
            s1_q     <= iTaps;
            s2_q     <= s1_q;
            cnt_q    <= cnt_d;
            missed_q <= hit && blocked;

            case (state_q)
                S_IDLE: begin
                    if (iArm) state_q <= S_ARMED;
                end
                S_ARMED: begin
                    // A hit wins over a disarm in the same cycle.
                    if (hit) begin
                        ff_q     <= s1_q;
                        coarse_q <= cnt_q;
                        valid_q  <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= S_HOLD;
                    end else if (!iArm) begin
                        state_q <= S_IDLE;
                    end
                end
                S_HOLD: begin
                    if (valid_q && iReady) begin
                        valid_q <= 1'b0;
                        if (DEAD > 0) begin
                            dcnt_q  <= DEAD_LD;
                            state_q <= S_DEAD;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= iArm ? S_ARMED : S_IDLE;
                        end
                    end
                end
                S_DEAD: begin
                    if (dcnt_q == '0) begin
                        busy_q  <= 1'b0;
                        state_q <= iArm ? S_ARMED : S_IDLE;
                    end else begin
                        dcnt_q <= dcnt_q - 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign oFF     = ff_q;
    assign oCoarse = coarse_q;
    assign oValid  = valid_q;
    assign oBusy   = busy_q;
    assign oMissed = missed_q;

endmodule

// File: tb/tb_tdc_tap_capture.sv
module tb_tdc_tap_capture;
    localparam int NUM  = 12;
    localparam int CW   = 16;
    localparam int DEAD = 4;

    logic            iClk = 1'b0;
    logic            iRstn = 1'b0;
    logic [NUM-1:0]  iTaps = '0;
    logic            iArm = 1'b0;
    logic            iReady = 1'b0;
    logic [NUM-1:0]  oFF;
    logic [CW-1:0]   oCoarse;
    logic            oValid, oBusy, oMissed;

    tdc_tap_capture #(.NUM(NUM), .COARSE_W(CW), .DEAD(DEAD)) dut (
        .iClk(iClk), .iRstn(iRstn), .iTaps(iTaps), .iArm(iArm), .iReady(iReady),
        .oFF(oFF), .oCoarse(oCoarse), .oValid(oValid), .oBusy(oBusy), .oMissed(oMissed)
    );

    always #5 iClk = ~iClk;

    typedef struct { logic [NUM-1:0] ff; logic [CW-1:0] coarse; } exp_t;
    typedef struct { logic [NUM-1:0] taps; logic [NUM-1:0] exp_ff; int rdy_wait; } vec_t;

    exp_t        sb[$];
    exp_t        e;
    vec_t        vecs[6];
    int          nchk = 0, nfail = 0;
    int          missed_seen = 0, exp_missed = 0;
    logic        valid_prev = 1'b0, missed_prev = 1'b0;
    logic [CW-1:0] ecnt;      // bench model of the coarse counter
    logic [CW-1:0] exp_c;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    // Drive a hit word right after an edge: s1 takes it at the next edge, and
    // the detect cycle then sees the count of that edge.
    task automatic push_hit(input logic [NUM-1:0] taps);
        exp_t x;
        x.ff     = taps;
        x.coarse = CW'(ecnt + 1'b1);
        exp_c    = x.coarse;
        sb.push_back(x);
        iTaps = taps;
    endtask

    always @(posedge iClk or negedge iRstn)
        if (!iRstn) ecnt <= '0;
        else        ecnt <= ecnt + 1'b1;

    // Scoreboard monitor: each new valid word must match the oldest pushed hit.
    always @(negedge iClk) begin
        if (iRstn) begin
            if (oValid && !valid_prev) begin
                if (sb.size() == 0) begin
                    nchk++; nfail++;
                    $display("FAIL unexpected_valid: got oFF=0x%0h required no word", oFF);
                end else begin
                    e = sb.pop_front();
                    chk("sb_ff", oFF, e.ff);
                    chk("sb_coarse", oCoarse, e.coarse);
                end
            end
            if (oMissed) begin
                missed_seen++;
                chk("missed_single_cycle", missed_prev, 0);
            end
        end
        valid_prev = oValid;
        missed_prev = oMissed;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{12'h001, 12'h001, 0};
        vecs[1] = '{12'hFFF, 12'hFFF, 3};
        vecs[2] = '{12'h7FF, 12'h7FF, 1};
        vecs[3] = '{12'h0F0, 12'h0F0, 0};   // bubble passes through untouched
        vecs[4] = '{12'h800, 12'h800, 2};
        vecs[5] = '{12'h555, 12'h555, 5};

        // Reset state
        #3;
        chk("rst_ff", oFF, 0); chk("rst_coarse", oCoarse, 0);
        chk("rst_valid", oValid, 0); chk("rst_busy", oBusy, 0); chk("rst_missed", oMissed, 0);
        #20 iRstn = 1'b1;

        // Basic capture
        iArm = 1'b1;
        repeat (10) tick();
        push_hit(12'h01F);
        tick(); chk("lat_first_edge", oValid, 0);
        tick(); chk("basic_valid", oValid, 1); chk("basic_busy", oBusy, 1);
        chk("basic_ff", oFF, 12'h01F); chk("basic_coarse", oCoarse, exp_c);

        // Backpressure with a dropped hit while holding
        for (int i = 0; i < 20; i++) begin
            if (i == 2)  iTaps = 12'h000;
            if (i == 5)  begin iTaps = 12'h003; exp_missed++; end
            if (i == 10) iTaps = 12'h000;
            tick();
            chk("hold_ff", oFF, 12'h01F); chk("hold_coarse", oCoarse, exp_c);
            chk("hold_valid", oValid, 1);
            if (i == 6) chk("hold_missed", oMissed, 1);
            if (i == 7) chk("hold_missed_end", oMissed, 0);
        end
        // Handshake, with a new hit landing in the first dead cycle
        iTaps = 12'h003; iReady = 1'b1; exp_missed++;
        tick(); iReady = 1'b0;
        chk("hs_valid", oValid, 0); chk("dead_busy0", oBusy, 1);
        tick(); chk("dead_missed", oMissed, 1); chk("dead_busy1", oBusy, 1);
        tick(); chk("dead_missed_end", oMissed, 0); chk("dead_busy2", oBusy, 1);
        chk("dead_ff_kept", oFF, 12'h01F);
        tick(); chk("dead_busy3", oBusy, 1);
        tick(); chk("dead_exit_busy", oBusy, 0);

        // Table-driven captures
        foreach (vecs[k]) begin
            iTaps = '0;
            repeat (3) tick();
            push_hit(vecs[k].taps);
            tick(); chk("vec_lat", oValid, 0);
            tick(); chk("vec_valid", oValid, 1); chk("vec_ff", oFF, vecs[k].exp_ff);
            chk("vec_coarse", oCoarse, exp_c);
            repeat (vecs[k].rdy_wait) tick();
            iReady = 1'b1; tick(); iReady = 1'b0;
            chk("vec_hs", oValid, 0);
            repeat (5) tick();
            chk("vec_idle_busy", oBusy, 0);
        end

        // Hit in the same cycle as the handshake is dropped
        iTaps = '0; repeat (3) tick();
        push_hit(12'h00F); tick(); tick();
        iTaps = '0; tick(); tick();
        iTaps = 12'h0A0; tick();
        iReady = 1'b1; exp_missed++; tick(); iReady = 1'b0;
        chk("hs_hit_valid", oValid, 0); chk("hs_hit_missed", oMissed, 1);
        chk("hs_hit_ff", oFF, 12'h00F);
        repeat (6) tick();

        // Disarm: no capture and no miss report while idle
        iArm = 1'b0; iTaps = '0; repeat (3) tick();
        iTaps = 12'h0FF;
        for (int i = 0; i < 6; i++) begin
            tick(); chk("idle_valid", oValid, 0); chk("idle_missed", oMissed, 0);
        end
        // Disarm in the detect cycle still captures
        iTaps = '0; iArm = 1'b1; repeat (3) tick();
        push_hit(12'h3C0); tick();
        iArm = 1'b0; tick();
        chk("disarm_hit_valid", oValid, 1); chk("disarm_hit_ff", oFF, 12'h3C0);
        iReady = 1'b1; tick(); iReady = 1'b0;
        repeat (5) tick();
        iTaps = '0; tick(); tick();
        iTaps = 12'h111;
        for (int i = 0; i < 4; i++) begin
            tick(); chk("post_dead_idle_valid", oValid, 0);
        end

        // Reset mid-HOLD
        iTaps = '0; iArm = 1'b1; repeat (3) tick();
        push_hit(12'h01F); tick(); tick();
        chk("pre_rst_valid", oValid, 1);
        @(negedge iClk); #1;
        iRstn = 1'b0; iTaps = '0; #1;
        chk("mid_rst_ff", oFF, 0); chk("mid_rst_coarse", oCoarse, 0);
        chk("mid_rst_valid", oValid, 0); chk("mid_rst_busy", oBusy, 0);
        chk("mid_rst_missed", oMissed, 0);
        #1 iRstn = 1'b1;
        repeat (4) tick();
        push_hit(12'h0C3); tick(); tick();
        chk("post_rst_valid", oValid, 1); chk("post_rst_ff", oFF, 12'h0C3);
        chk("post_rst_coarse", oCoarse, exp_c);
        iReady = 1'b1; tick(); iReady = 1'b0;
        iTaps = '0;

        // Counter wrap: hit at 0xFFFF, a dropped one at 0x0003 inside the
        // dead window, and the next accepted one at 0x0008
        for (int n = 0; n < 70000 && ecnt != 16'hFFFE; n++) tick();
        chk("wrap_reach", ecnt, 16'hFFFE);
        push_hit(12'h01F); tick(); tick();
        chk("wrap_valid", oValid, 1); chk("wrap_coarse_ffff", oCoarse, 16'hFFFF);
        iTaps = '0; iReady = 1'b1; tick(); iReady = 1'b0;
        tick();
        iTaps = 12'h003; exp_missed++; tick();
        tick(); chk("wrap_dead_missed", oMissed, 1);
        iTaps = '0; tick(); tick(); tick();
        push_hit(12'h00F); tick(); tick();
        chk("wrap_valid2", oValid, 1); chk("wrap_coarse_8", oCoarse, 16'h0008);
        iReady = 1'b1; tick(); iReady = 1'b0;
        repeat (6) tick();

        chk("missed_total", missed_seen, exp_missed);
        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
